// File: rtl/lidar_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lidar_pkg
//  Description : Shared state encoding and constants for the TOF capture path.
//  Revision    : 1.0 - initial release
// ============================================================================
package lidar_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DRAIN = 2'd2
  } tof_state_t;

  // Wide all-ones; users slice it down to their counter width.
  localparam logic [31:0] TOF_NO_RETURN = 32'hFFFF_FFFF;

  localparam int TOF_MAX_ECHO_LIMIT = 3;

endpackage
`default_nettype wire

// File: rtl/rise_detect.sv
`default_nettype none
// ============================================================================
//  Module      : rise_detect
//  Description : Rising-edge pulse against a one-cycle-delayed copy, with an
//                optional synchronizer chain (SYNC_STAGES = 0 bypasses it).
//  Revision    : 1.0 - initial release
// ============================================================================
module rise_detect #(
  parameter int SYNC_STAGES = 0
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_level,
  output logic o_rise
);

  logic w_sig;
  logic r_prev;

  generate
    if (SYNC_STAGES > 0) begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;

      always_ff @(posedge CLK) begin
        if (RST) begin
          r_sync <= '0;
        end else begin
          r_sync[0] <= i_level;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
          end
        end
      end

      assign w_sig = r_sync[SYNC_STAGES-1];
    end else begin : g_direct
      assign w_sig = i_level;
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_sig;
    end
  end

  assign o_rise = w_sig & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/tof_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tof_capture
//  Description : Measures cycles from laser start edge to up to MAX_ECHO echo
//                edges inside a window; results leave on a valid/ready stream.
//                Define TOF_ECHO_SYNC_EN to add a 2-flop ECHO synchronizer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tof_capture
  import lidar_pkg::*;
#(
  parameter int COUNTER_WIDTH = 17,
  parameter int MAX_ECHO      = 3
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     EN,
  input  logic                     START,
  input  logic                     ECHO,
  input  logic [COUNTER_WIDTH-1:0] WINDOW,
  output logic                     TOF_VALID,
  input  logic                     TOF_READY,
  output logic [COUNTER_WIDTH-1:0] TOF_DATA,
  output logic [1:0]               TOF_IDX,
  output logic                     TOF_LAST,
  output logic                     OVERRUN,
  output logic                     BUSY
);

`ifdef TOF_ECHO_SYNC_EN
  localparam int c_echo_sync = 2;
`else
  localparam int c_echo_sync = 0;
`endif

  localparam logic [COUNTER_WIDTH-1:0] c_no_return = TOF_NO_RETURN[COUNTER_WIDTH-1:0];
  localparam logic [COUNTER_WIDTH-1:0] c_win_max   = c_no_return - 1'b1;
  localparam logic [COUNTER_WIDTH-1:0] c_win_min   = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [1:0]               c_max_echo  = 2'(MAX_ECHO);

  tof_state_t               r_state;
  logic [COUNTER_WIDTH-1:0] r_tof;
  logic [COUNTER_WIDTH-1:0] r_window;
  logic [1:0]               r_cnt;
  logic [COUNTER_WIDTH-1:0] r_store [4];
  logic                     r_valid;
  logic [COUNTER_WIDTH-1:0] r_data;
  logic [1:0]               r_idx;
  logic                     r_last;
  logic                     r_overrun;
  logic                     r_busy;

  logic                     w_start_rise;
  logic                     w_echo_rise;
  logic [COUNTER_WIDTH-1:0] w_win_clamped;
  logic                     w_capture;
  logic [1:0]               w_cnt_next;
  logic                     w_term;
  logic [1:0]               w_load_idx;
  logic [COUNTER_WIDTH-1:0] w_load_data;
  logic                     w_load_last;

  rise_detect #(.SYNC_STAGES(0)) u_start_rise (
    .CLK     (CLK),
    .RST     (RST),
    .i_level (START),
    .o_rise  (w_start_rise)
  );

  rise_detect #(.SYNC_STAGES(c_echo_sync)) u_echo_rise (
    .CLK     (CLK),
    .RST     (RST),
    .i_level (ECHO),
    .o_rise  (w_echo_rise)
  );

  always_comb begin
    w_win_clamped = WINDOW;
    if (WINDOW == '0) begin
      w_win_clamped = c_win_min;
    end else if (WINDOW == c_no_return) begin
      w_win_clamped = c_win_max;
    end
  end

  assign w_capture  = (r_state == ARMED) && w_echo_rise && (r_cnt < c_max_echo);
  assign w_cnt_next = w_capture ? r_cnt + 2'd1 : r_cnt;
  // An echo landing on the terminating cycle is already counted in w_cnt_next.
  assign w_term     = (r_tof == r_window) || (w_cnt_next == c_max_echo);

  assign w_load_idx  = r_valid ? r_idx + 2'd1 : 2'd0;
  assign w_load_data = (r_cnt == 2'd0) ? c_no_return : r_store[w_load_idx];
  assign w_load_last = (r_cnt == 2'd0) || (w_load_idx == r_cnt - 2'd1);

  always_ff @(posedge CLK) begin
    if (w_capture) begin
      r_store[r_cnt] <= r_tof;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_tof     <= '0;
      r_window  <= '0;
      r_cnt     <= 2'd0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_idx     <= 2'd0;
      r_last    <= 1'b0;
      r_overrun <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_overrun <= w_start_rise && (r_state != IDLE);
      if (!EN) begin
        r_state <= IDLE;
        r_valid <= 1'b0;
        r_cnt   <= 2'd0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_start_rise) begin
              r_state  <= ARMED;
              r_tof    <= c_win_min;
              r_window <= w_win_clamped;
              r_cnt    <= 2'd0;
              r_busy   <= 1'b1;
            end
          end
          ARMED: begin
            r_tof <= r_tof + 1'b1;
            r_cnt <= w_cnt_next;
            if (w_term) begin
              r_state <= DRAIN;
            end
          end
          DRAIN: begin
            if (!r_valid || TOF_READY) begin
              if (r_valid && r_last) begin
                r_state <= IDLE;
                r_valid <= 1'b0;
                r_busy  <= 1'b0;
              end else begin
                r_valid <= 1'b1;
                r_data  <= w_load_data;
                r_idx   <= w_load_idx;
                r_last  <= w_load_last;
              end
            end
          end
          default: begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign TOF_VALID = r_valid;
  assign TOF_DATA  = r_data;
  assign TOF_IDX   = r_idx;
  assign TOF_LAST  = r_last;
  assign OVERRUN   = r_overrun;
  assign BUSY      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_tof_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tof_capture
//  Description : Self-checking bench for tof_capture (default build).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tof_capture;

  localparam int            CW     = 17;
  localparam logic [CW-1:0] NO_RET = 17'h1FFFF;

  logic          CLK = 1'b0;
  logic          RST;
  logic          EN;
  logic          START;
  logic          ECHO;
  logic [CW-1:0] WINDOW;
  logic          TOF_VALID;
  logic          TOF_READY;
  logic [CW-1:0] TOF_DATA;
  logic [1:0]    TOF_IDX;
  logic          TOF_LAST;
  logic          OVERRUN;
  logic          BUSY;

  int checks = 0;
  int errors = 0;

  logic [CW-1:0] q_data [$];
  logic [1:0]    q_idx  [$];
  logic          q_last [$];
  int            first_valid_p;
  bit            seen;

  typedef struct packed {
    logic [CW-1:0]         win;
    int                    n;
    logic [3:0][CW-1:0]    off;
    int                    rmode;
    int                    ovr;
    int                    exp_n;
    logic [2:0][CW-1:0]    exp_d;
    int                    exp_term;
  } vec_t;

  vec_t vt [9];

  tof_capture #(.COUNTER_WIDTH(CW), .MAX_ECHO(3)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .EN        (EN),
    .START     (START),
    .ECHO      (ECHO),
    .WINDOW    (WINDOW),
    .TOF_VALID (TOF_VALID),
    .TOF_READY (TOF_READY),
    .TOF_DATA  (TOF_DATA),
    .TOF_IDX   (TOF_IDX),
    .TOF_LAST  (TOF_LAST),
    .OVERRUN   (OVERRUN),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(int w, int n, int o0, int o1, int o2, int o3, int rm, int ov,
                              int en, int d0, int d1, int d2, int term);
    vec_t v;
    v.win      = CW'(w);
    v.n        = n;
    v.off[0]   = CW'(o0);
    v.off[1]   = CW'(o1);
    v.off[2]   = CW'(o2);
    v.off[3]   = CW'(o3);
    v.rmode    = rm;
    v.ovr      = ov;
    v.exp_n    = en;
    v.exp_d[0] = CW'(d0);
    v.exp_d[1] = CW'(d1);
    v.exp_d[2] = CW'(d2);
    v.exp_term = term;
    return v;
  endfunction

  // Reference: capture each echo offset that falls inside the (clamped) window
  // until three are held; the shot ends at the window or at the third echo.
  task automatic model(input logic [CW-1:0] win, input int n, input logic [3:0][CW-1:0] off,
                       output int en, output logic [2:0][CW-1:0] ed, output int term);
    int wc;
    wc   = (win == '0) ? 1 : (win == NO_RET) ? int'(NO_RET) - 1 : int'(win);
    en   = 0;
    ed   = '0;
    term = wc;
    for (int i = 0; i < n; i++) begin
      int k;
      k = int'(off[i]);
      if (k >= 1 && k <= term && en < 3) begin
        ed[en] = CW'(k);
        en++;
        if (en == 3) term = k;
      end
    end
    if (en == 0) begin
      en    = 1;
      ed[0] = NO_RET;
    end
  endtask

  // p counts posedges from the start edge (p=0); each iteration samples at the
  // negedge before posedge p, then drives the inputs seen at posedge p.
  task automatic run_shot(input logic [CW-1:0] win, input int n, input logic [3:0][CW-1:0] off,
                          input int rmode, input int ovr_rel);
    int            p;
    int            vcnt;
    bit            done;
    bit            hold;
    logic [CW-1:0] hd;
    logic [1:0]    hi;
    logic          hl;
    q_data.delete();
    q_idx.delete();
    q_last.delete();
    first_valid_p = -1;
    done = 1'b0;
    hold = 1'b0;
    vcnt = 0;
    hd   = '0;
    hi   = '0;
    hl   = 1'b0;
    for (p = 0; p < int'(win) + 300 && !done; p++) begin
      @(negedge CLK);
      if (p == 0) chk("busy_before_start", 32'(BUSY), 32'd0);
      if (p == 1) chk("busy_after_start", 32'(BUSY), 32'd1);
      if (p >= 1) chk($sformatf("overrun_p%0d", p), 32'(OVERRUN), 32'(ovr_rel >= 0 && p == ovr_rel + 1));
      if (hold) begin
        chk("hold_valid", 32'(TOF_VALID), 32'd1);
        chk("hold_data", 32'(TOF_DATA), 32'(hd));
        chk("hold_idx", 32'(TOF_IDX), 32'(hi));
        chk("hold_last", 32'(TOF_LAST), 32'(hl));
      end
      if (TOF_VALID && first_valid_p < 0) first_valid_p = p;
      START  = (p == 0) || (p == ovr_rel);
      WINDOW = (p == 0) ? win : CW'($urandom);
      ECHO   = 1'b0;
      for (int i = 0; i < n; i++) if (int'(off[i]) == p) ECHO = 1'b1;
      case (rmode)
        0:       TOF_READY = 1'b1;
        1:       TOF_READY = TOF_VALID && (vcnt >= 4);
        default: TOF_READY = ($urandom % 3) != 0;
      endcase
      if (TOF_VALID) vcnt++;
      hold = TOF_VALID && !TOF_READY;
      hd   = TOF_DATA;
      hi   = TOF_IDX;
      hl   = TOF_LAST;
      if (TOF_VALID && TOF_READY) begin
        q_data.push_back(TOF_DATA);
        q_idx.push_back(TOF_IDX);
        q_last.push_back(TOF_LAST);
        if (TOF_LAST) done = 1'b1;
      end
    end
    chk("shot_completed", 32'(done), 32'd1);
    @(negedge CLK);
    START = 1'b0;
    ECHO  = 1'b0;
    chk("idle_after_last_busy", 32'(BUSY), 32'd0);
    chk("idle_after_last_valid", 32'(TOF_VALID), 32'd0);
  endtask

  task automatic check_shot(input string tag, input int exp_n, input logic [2:0][CW-1:0] exp_d,
                            input int exp_term);
    chk({tag, "_count"}, 32'(q_data.size()), 32'(exp_n));
    chk({tag, "_first_valid"}, 32'(first_valid_p), 32'(exp_term + 2));
    for (int i = 0; i < exp_n && i < q_data.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), 32'(q_data[i]), 32'(exp_d[i]));
      chk($sformatf("%s_idx%0d", tag, i), 32'(q_idx[i]), 32'(i));
      chk($sformatf("%s_last%0d", tag, i), 32'(q_last[i]), 32'(i == exp_n - 1));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST       = 1'b1;
    EN        = 1'b1;
    START     = 1'b0;
    ECHO      = 1'b0;
    TOF_READY = 1'b0;
    WINDOW    = '0;

    //        win  n  offsets           rm ovr exp_n data                 term
    vt[0] = mk(100, 1, 37, 0, 0, 0,      0, -1, 1, 37, 0, 0,              100);
    vt[1] = mk( 50, 0,  0, 0, 0, 0,      0, -1, 1, int'(NO_RET), 0, 0,    50);
    vt[2] = mk(100, 4,  5, 9, 12, 20,    0, -1, 3, 5, 9, 12,              12);
    vt[3] = mk(100, 4,  5, 9, 12, 20,    1, -1, 3, 5, 9, 12,              12);
    vt[4] = mk( 30, 1, 10, 0, 0, 0,      0,  5, 1, 10, 0, 0,              30);
    vt[5] = mk(  0, 1,  1, 0, 0, 0,      0, -1, 1, 1, 0, 0,               1);
    vt[6] = mk( 10, 2,  0, 4, 0, 0,      0, -1, 1, 4, 0, 0,               10);
    vt[7] = mk( 20, 3,  3, 20, 22, 0,    2, -1, 2, 3, 20, 0,              20);
    vt[8] = mk(  8, 1,  9, 0, 0, 0,      0, -1, 1, int'(NO_RET), 0, 0,    8);

    repeat (3) @(negedge CLK);
    chk("rst_valid", 32'(TOF_VALID), 32'd0);
    chk("rst_data", 32'(TOF_DATA), 32'd0);
    chk("rst_idx", 32'(TOF_IDX), 32'd0);
    chk("rst_last", 32'(TOF_LAST), 32'd0);
    chk("rst_overrun", 32'(OVERRUN), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    for (int v = 0; v < 9; v++) begin
      run_shot(vt[v].win, vt[v].n, vt[v].off, vt[v].rmode, vt[v].ovr);
      check_shot($sformatf("vec%0d", v), vt[v].exp_n, vt[v].exp_d, vt[v].exp_term);
    end

    // EN dropped while an entry is waiting in DRAIN.
    seen = 1'b0;
    for (int p = 0; p < 60 && !seen; p++) begin
      @(negedge CLK);
      if (TOF_VALID) begin
        seen = 1'b1;
      end else begin
        START     = (p == 0);
        WINDOW    = CW'(20);
        ECHO      = (p == 3) || (p == 6);
        TOF_READY = 1'b0;
      end
    end
    chk("en_drop_valid_seen", 32'(seen), 32'd1);
    START = 1'b0;
    ECHO  = 1'b0;
    EN    = 1'b0;
    @(negedge CLK);
    chk("en_drop_valid", 32'(TOF_VALID), 32'd0);
    chk("en_drop_busy", 32'(BUSY), 32'd0);
    EN = 1'b1;
    begin
      logic [3:0][CW-1:0] none;
      logic [2:0][CW-1:0] ed;
      none  = '0;
      ed    = '0;
      ed[0] = NO_RET;
      run_shot(CW'(12), 0, none, 0, -1);
      check_shot("after_en", 1, ed, 12);
    end

    // RST asserted while ARMED, then a clean shot.
    for (int p = 0; p <= 10; p++) begin
      @(negedge CLK);
      if (p == 10) chk("pre_rst_busy", 32'(BUSY), 32'd1);
      START  = (p == 0);
      WINDOW = CW'(40);
      ECHO   = (p == 4);
      RST    = (p == 10);
    end
    @(negedge CLK);
    RST  = 1'b0;
    ECHO = 1'b0;
    chk("mid_rst_valid", 32'(TOF_VALID), 32'd0);
    chk("mid_rst_data", 32'(TOF_DATA), 32'd0);
    chk("mid_rst_idx", 32'(TOF_IDX), 32'd0);
    chk("mid_rst_last", 32'(TOF_LAST), 32'd0);
    chk("mid_rst_overrun", 32'(OVERRUN), 32'd0);
    chk("mid_rst_busy", 32'(BUSY), 32'd0);
    begin
      logic [3:0][CW-1:0] o;
      logic [2:0][CW-1:0] ed;
      o     = '0;
      o[0]  = CW'(15);
      ed    = '0;
      ed[0] = CW'(15);
      run_shot(CW'(40), 1, o, 0, -1);
      check_shot("after_rst", 1, ed, 40);
    end

    // Randomized shots against the reference model.
    for (int s = 0; s < 25; s++) begin
      logic [CW-1:0]      win;
      logic [3:0][CW-1:0] o;
      logic [2:0][CW-1:0] ed;
      int                 n, cur, en, term, wc, ovr;
      win = ($urandom % 8 == 0) ? '0 : CW'($urandom_range(1, 60));
      n   = $urandom_range(0, 4);
      o   = '0;
      cur = $urandom_range(1, 8);
      for (int i = 0; i < 4; i++) begin
        o[i] = CW'(cur);
        cur += $urandom_range(2, 15);
      end
      wc  = (win == '0) ? 1 : int'(win);
      ovr = (wc >= 2 && ($urandom % 4 == 0)) ? $urandom_range(2, wc) : -1;
      model(win, n, o, en, ed, term);
      if (ovr > term) ovr = -1;
      run_shot(win, n, o, $urandom_range(0, 2), ovr);
      check_shot($sformatf("rnd%0d", s), en, ed, term);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
